// File: rtl/host_fifo_pkg.sv
// host_fifo_pkg: shared widths and the beat record stored per FIFO entry
// for host_stream_fifo and host_fifo_ram.
package host_fifo_pkg;

   localparam int DATA_W = 512;
   localparam int KEEP_W = DATA_W / 8;
   localparam int ID_W   = 6;

   // One AXI4-Stream beat, packed so it occupies a single memory word.
   typedef struct packed {
      logic              tlast;
      logic [ID_W-1:0]   tid;
      logic [KEEP_W-1:0] tkeep;
      logic [DATA_W-1:0] tdata;
   } beat_t;

   localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/host_fifo_ram.sv
// host_fifo_ram: simple dual-port beat storage with a synchronous write port
// and an asynchronous read port addressed directly by the read pointer.
module host_fifo_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the accepted beat into its slot.
   // NOTE: the array has no reset; its contents are only meaningful between
   // the pointers, and resetting it would force it out of RAM primitives.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Present the slot under the read pointer combinationally.
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/host_stream_fifo.sv
// host_stream_fifo: elastic packet-aware buffer between the host AXI4-Stream
// and the cipher stage. Beats pass unmodified and in order; occupancy and
// packet counters are exported for debug CSRs.
// Optional build macro HOST_FIFO_SAF_EN selects store-and-forward: output is
// held back until a whole packet is stored (or the buffer fills, in which
// case it falls back to cut-through and sets the sticky saf_overflow flag).
module host_stream_fifo
   import host_fifo_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = DATA_W,
   parameter int ID_WIDTH         = ID_W,
   parameter int DEPTH            = 16
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_host_tdata,
   input  logic [AXIS_TDATA_WIDTH/8-1:0]   s_axis_host_tkeep,
   input  logic [ID_WIDTH-1:0]             s_axis_host_tid,
   input  logic                            s_axis_host_tlast,
   input  logic                            s_axis_host_tvalid,
   output logic                            s_axis_host_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [ID_WIDTH-1:0]             m_axis_tid,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [$clog2(DEPTH):0]          occupancy,
   output logic [$clog2(DEPTH):0]          pkts_stored,
   output logic [31:0]                     pkts_out
`ifdef HOST_FIFO_SAF_EN
   ,
   output logic                            saf_overflow
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] occupancy_q, occupancy_d;
   logic [CNT_W-1:0] pkts_stored_q, pkts_stored_d;
   logic [31:0]      pkts_out_q, pkts_out_d;
   logic             s_tready_q, s_tready_d;
   logic             m_tvalid_q, m_tvalid_d;
`ifdef HOST_FIFO_SAF_EN
   logic             draining_q, draining_d;
   logic             saf_overflow_q, saf_overflow_d;
`endif

   beat_t wr_beat, rd_beat;
   logic  push, pop;

   // Handshakes only ever use the registered ready/valid, so full and empty
   // never create a same-cycle path from one side of the buffer to the other.
   assign push = s_axis_host_tvalid & s_tready_q;
   assign pop  = m_tvalid_q & m_axis_tready;

   // Pack the incoming beat into a single storage word.
   always_comb begin
      wr_beat.tlast = s_axis_host_tlast;
      wr_beat.tid   = s_axis_host_tid;
      wr_beat.tkeep = s_axis_host_tkeep;
      wr_beat.tdata = s_axis_host_tdata;
   end

   host_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (BEAT_W)
   ) u_ram (
      .clk   (aclk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_beat),
      .raddr (rd_ptr_q),
      .rdata (rd_beat)
   );

   // Next-state for pointers, counters and the registered handshakes.
   // NOTE: every _d gets its hold value first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      occupancy_d   = occupancy_q;
      pkts_stored_d = pkts_stored_q;
      pkts_out_d    = pkts_out_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
         2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
         default: occupancy_d = occupancy_q;
      endcase

      case ({push && s_axis_host_tlast, pop && rd_beat.tlast})
         2'b10:   pkts_stored_d = pkts_stored_q + CNT_W'(1);
         2'b01:   pkts_stored_d = pkts_stored_q - CNT_W'(1);
         default: pkts_stored_d = pkts_stored_q;
      endcase

      if (pop && rd_beat.tlast) pkts_out_d = pkts_out_q + 32'd1;

      s_tready_d = (occupancy_d != FULL_CNT);

`ifdef HOST_FIFO_SAF_EN
      // A packet that has started leaving keeps flowing until its tlast pops.
      draining_d = draining_q;
      if (pop) draining_d = !rd_beat.tlast;
      saf_overflow_d = saf_overflow_q |
                       ((occupancy_d == FULL_CNT) && (pkts_stored_d == '0));
      m_tvalid_d = (occupancy_d != '0) &&
                   ((pkts_stored_d != '0) || (occupancy_d == FULL_CNT) || draining_d);
`else
      m_tvalid_d = (occupancy_d != '0);
`endif
   end

   // State registers; everything is cleared asynchronously, storage is not.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         occupancy_q    <= '0;
         pkts_stored_q  <= '0;
         pkts_out_q     <= '0;
         s_tready_q     <= 1'b0;
         m_tvalid_q     <= 1'b0;
`ifdef HOST_FIFO_SAF_EN
         draining_q     <= 1'b0;
         saf_overflow_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         occupancy_q    <= occupancy_d;
         pkts_stored_q  <= pkts_stored_d;
         pkts_out_q     <= pkts_out_d;
         s_tready_q     <= s_tready_d;
         m_tvalid_q     <= m_tvalid_d;
`ifdef HOST_FIFO_SAF_EN
         draining_q     <= draining_d;
         saf_overflow_q <= saf_overflow_d;
`endif
      end
   end

   assign s_axis_host_tready = s_tready_q;
   assign m_axis_tvalid      = m_tvalid_q;
   assign m_axis_tdata       = rd_beat.tdata;
   assign m_axis_tkeep       = rd_beat.tkeep;
   assign m_axis_tid         = rd_beat.tid;
   assign m_axis_tlast       = rd_beat.tlast;
   assign occupancy          = occupancy_q;
   assign pkts_stored        = pkts_stored_q;
   assign pkts_out           = pkts_out_q;
`ifdef HOST_FIFO_SAF_EN
   assign saf_overflow       = saf_overflow_q;
`endif

endmodule

// File: tb/tb_host_stream_fifo.sv
// tb_host_stream_fifo: directed stimulus with a scoreboard queue; a separate
// monitor compares every beat leaving m_axis against the queue.
module tb_host_stream_fifo;
   import host_fifo_pkg::*;

   localparam int DEPTH = 16;

   logic              aclk;
   logic              areset;
   logic [DATA_W-1:0] s_tdata;
   logic [KEEP_W-1:0] s_tkeep;
   logic [ID_W-1:0]   s_tid;
   logic              s_tlast, s_tvalid, s_tready;
   logic [DATA_W-1:0] m_tdata;
   logic [KEEP_W-1:0] m_tkeep;
   logic [ID_W-1:0]   m_tid;
   logic              m_tlast, m_tvalid, m_tready;
   logic [4:0]        occupancy, pkts_stored;
   logic [31:0]       pkts_out;
`ifdef HOST_FIFO_SAF_EN
   logic              saf_overflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   beat_t exp_q[$];

   host_stream_fifo #(.AXIS_TDATA_WIDTH(DATA_W), .ID_WIDTH(ID_W), .DEPTH(DEPTH)) dut (
      .aclk               (aclk),
      .areset             (areset),
      .s_axis_host_tdata  (s_tdata),
      .s_axis_host_tkeep  (s_tkeep),
      .s_axis_host_tid    (s_tid),
      .s_axis_host_tlast  (s_tlast),
      .s_axis_host_tvalid (s_tvalid),
      .s_axis_host_tready (s_tready),
      .m_axis_tdata       (m_tdata),
      .m_axis_tkeep       (m_tkeep),
      .m_axis_tid         (m_tid),
      .m_axis_tlast       (m_tlast),
      .m_axis_tvalid      (m_tvalid),
      .m_axis_tready      (m_tready),
      .occupancy          (occupancy),
      .pkts_stored        (pkts_stored),
      .pkts_out           (pkts_out)
`ifdef HOST_FIFO_SAF_EN
      ,
      .saf_overflow       (saf_overflow)
`endif
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t mk(input logic [7:0] pat, input logic [KEEP_W-1:0] keep,
                                input logic [ID_W-1:0] id, input logic last);
      beat_t b;
      b.tdata = {(DATA_W/8){pat}};
      b.tkeep = keep;
      b.tid   = id;
      b.tlast = last;
      return b;
   endfunction

   function automatic logic [KEEP_W-1:0] rnd_keep();
      return {$urandom(), $urandom()};
   endfunction

   // Drive one beat and wait (bounded) for acceptance; returns at edge + 1.
   task automatic send(input beat_t b);
      bit ok = 1'b0;
      s_tdata  = b.tdata;
      s_tkeep  = b.tkeep;
      s_tid    = b.tid;
      s_tlast  = b.tlast;
      s_tvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk);
         if (s_tready) begin
            exp_q.push_back(b);
            ok = 1'b1;
            @(posedge aclk);
            #1;
            break;
         end
         @(posedge aclk);
         #1;
      end
      s_tvalid = 1'b0;
      check("send accepted in time", ok, 1'b1);
   endtask

   // Wait (bounded) until every expected beat has been seen on m_axis.
   task automatic drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge aclk);
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      #1;
      check({name, " drained"}, done, 1'b1);
   endtask

   // Monitor: a transfer happens at the next rising edge whenever valid and
   // ready are both high at the falling edge.
   initial begin
      beat_t got, exp;
      forever begin
         @(negedge aclk);
         if (areset && m_tvalid && m_tready) begin
            got.tdata = m_tdata;
            got.tkeep = m_tkeep;
            got.tid   = m_tid;
            got.tlast = m_tlast;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL m_axis unexpected beat: got %0h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               check("m_axis beat", got, exp);
            end
         end
      end
   end

   initial begin
      areset   = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tid    = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;

      // Reset state.
      repeat (3) @(posedge aclk);
      #1;
      check("reset m_tvalid", m_tvalid, 1'b0);
      check("reset s_tready", s_tready, 1'b0);
      check("reset occupancy", occupancy, 0);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      check("post-reset s_tready", s_tready, 1'b1);
      check("post-reset pkts_out", pkts_out, 0);
      check("post-reset pkts_stored", pkts_stored, 0);

      // Single beat with 1-cycle fall-through.
      m_tready = 1'b1;
      send(mk(8'hA5, '1, 6'd3, 1'b1));
      check("single latency m_tvalid", m_tvalid, 1'b1);
      check("single occupancy 1", occupancy, 1);
      @(posedge aclk);
      #1;
      check("single occupancy 0", occupancy, 0);
      check("single pkts_out", pkts_out, 1);
      check("single m_tvalid low", m_tvalid, 1'b0);

      // Fill to DEPTH, 17th beat held, then drain in order.
      m_tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(mk(8'(8'h10 + i), '1, 6'(i), 1'b1));
      check("full s_tready", s_tready, 1'b0);
      check("full occupancy", occupancy, 16);
      check("full pkts_stored", pkts_stored, 16);
      s_tdata  = {(DATA_W/8){8'hEE}};
      s_tkeep  = '1;
      s_tid    = 6'h2A;
      s_tlast  = 1'b1;
      s_tvalid = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("held beat not accepted", occupancy, 16);
      check("held s_tready", s_tready, 1'b0);
      m_tready = 1'b1;
      send(mk(8'hEE, '1, 6'h2A, 1'b1));
      drain("full");
      check("full drain occupancy", occupancy, 0);
      check("full drain pkts_out", pkts_out, 18);

      // Steady push+pop at occupancy 8.
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) send(mk(8'(8'h40 + i), rnd_keep(), 6'(i + 20), 1'b1));
      check("steady preload occupancy", occupancy, 8);
      m_tready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         send(mk(8'(8'h80 + i), rnd_keep(), 6'(i), 1'b1));
         check("steady occupancy", occupancy, 8);
      end
      drain("steady");
      check("steady pkts_out", pkts_out, 76);

      // Reset mid-packet.
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) send(mk(8'(8'hC0 + i), '1, 6'd7, 1'b0));
      check("midpkt occupancy", occupancy, 5);
      areset = 1'b0;
      #1;
      check("midpkt reset m_tvalid", m_tvalid, 1'b0);
      check("midpkt reset s_tready", s_tready, 1'b0);
      exp_q.delete();
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      check("after reset occupancy", occupancy, 0);
      check("after reset pkts_stored", pkts_stored, 0);
      check("after reset pkts_out", pkts_out, 0);
      m_tready = 1'b1;
      send(mk(8'h5A, rnd_keep(), 6'd9, 1'b1));
      drain("after reset");
      check("after reset pkts_out 1", pkts_out, 1);

      // pkts_out wrap.
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) send(mk(8'(8'hD0 + i), '1, 6'(i), 1'b1));
      force dut.pkts_out_q = 32'hFFFF_FFFE;
      #1;
      release dut.pkts_out_q;
      m_tready = 1'b1;
      @(posedge aclk);
      #1;
      check("wrap pkts_out ffffffff", pkts_out, 32'hFFFF_FFFF);
      @(posedge aclk);
      #1;
      check("wrap pkts_out 0", pkts_out, 0);
      @(posedge aclk);
      #1;
      check("wrap pkts_out 1", pkts_out, 1);
      drain("wrap");

`ifdef HOST_FIFO_SAF_EN
      // Store-and-forward: hold until tlast is stored.
      check("saf_overflow initially", saf_overflow, 1'b0);
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) send(mk(8'(8'h60 + i), '1, 6'd5, 1'b0));
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk);
         #1;
         check("saf held m_tvalid", m_tvalid, 1'b0);
      end
      send(mk(8'h63, '1, 6'd5, 1'b1));
      for (int i = 0; i < 4; i++) begin
         check("saf burst m_tvalid", m_tvalid, 1'b1);
         @(posedge aclk);
         #1;
      end
      check("saf burst done", m_tvalid, 1'b0);

      // Packet longer than DEPTH falls back to cut-through.
      m_tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(mk(8'(8'h70 + i), '1, 6'd6, 1'b0));
      check("saf overflow flag", saf_overflow, 1'b1);
      check("saf fallback m_tvalid", m_tvalid, 1'b1);
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send(mk(8'(8'h90 + i), '1, 6'd6, i == 3));
      drain("saf long");
      check("saf long pkts_stored", pkts_stored, 0);
`endif

      repeat (2) @(posedge aclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/host_stream_fifo.md
Name: host_stream_fifo

Overview:
- Elastic packet-aware buffer on the host AXI4SR stream, directly upstream of the cipher user-logic stage.
- Decouples host back-pressure from the HLS core.
- Keeps complete packets (tdata/tkeep/tid/tlast) intact.
- Exposes occupancy and packet counters for debug CSRs.

Parameters:
- AXIS_TDATA_WIDTH, 512, data bus width in bits; tkeep width is AXIS_TDATA_WIDTH/8.
- ID_WIDTH, 6, width of tid.
- DEPTH, 16, number of beat entries; power of two, minimum 4.

Ports:
- aclk  in  1  single clock for the whole block.
- areset  in  1  asynchronous, active-low reset.
- s_axis_host  AXI4SR.s  AXIS_TDATA_WIDTH/ID_WIDTH  beat input from host (tdata, tkeep, tid, tlast, tvalid, tready).
- m_axis  AXI4SR.m  AXIS_TDATA_WIDTH/ID_WIDTH  beat output toward cipher stage.
- occupancy  out  $clog2(DEPTH)+1  number of beats currently stored.
- pkts_stored  out  $clog2(DEPTH)+1  number of tlast beats currently stored.
- pkts_out  out  32  count of tlast beats handed off on m_axis; wraps modulo 2^32.

Behaviour:
- Reset, asynchronous assert, active-low, release synchronous to aclk:
  - write pointer, read pointer, occupancy, pkts_stored, pkts_out all 0.
  - m_axis.tvalid = 0; s_axis_host.tready = 0 while areset is low.
  - Storage contents are not reset.
- Reset mid-packet discards all stored beats. No partial-packet recovery.
- Push:
  - s_axis_host.tready = (occupancy != DEPTH), registered.
  - A beat is accepted when tvalid && tready at a rising edge. It is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop:
  - m_axis.tvalid = (occupancy != 0), registered.
  - m_axis payload is always the entry at rd_ptr.
  - A beat leaves when tvalid && tready. rd_ptr increments modulo DEPTH.
- Latency: a beat accepted at edge N is presented on m_axis at edge N+1 when the FIFO was empty (1-cycle fall-through). Otherwise it is presented in order behind older beats.
- Payload:
  - Beats are never reordered, modified, split or merged.
  - tkeep and tid pass bit-exact.
- Occupancy update per edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- pkts_stored update: +1 on push with tlast, -1 on pop with tlast, net on simultaneous.
- Full: tready is low, no write. A pop in the same cycle raises tready for the next cycle. There is no same-cycle pass-through when full.
- Empty: tvalid is low and a pop is impossible. A push into empty raises tvalid the next cycle.
- pkts_out increments on each popped tlast beat and wraps from 0xFFFFFFFF to 0.
- Once tvalid is high, the m_axis payload is held stable until the beat is accepted (AXI-stream rule).

Optional Feature:
- Macro HOST_FIFO_SAF_EN (store-and-forward).
- With the macro defined:
  - m_axis.tvalid requires pkts_stored != 0, or occupancy == DEPTH.
  - The full-without-tlast case is a cut-through fallback that prevents deadlock on packets longer than DEPTH. It sets the sticky output saf_overflow (1 bit, cleared only by reset).
  - Once a packet starts draining, tvalid stays asserted until that packet's tlast pops, unless the FIFO empties.
- Without the macro: pure cut-through as in Behaviour, and saf_overflow is absent.

Decomposition:
- Package host_fifo_pkg contains:
  - localparams DATA_W, KEEP_W = DATA_W/8, ID_W.
  - packed struct beat_t {tlast, tid, tkeep, tdata}, stored as one memory word.
- One sub-module: host_fifo_ram.
  - Simple dual-port array, DEPTH x $bits(beat_t).
  - Synchronous write, asynchronous read by address.
  - No reset.
- Pointers, counters and handshake logic stay in host_stream_fifo.

Test Plan:
- Single beat, tdata=0xA5 repeated, tkeep all-ones, tid=3, tlast=1, m tready=1 → output 1 cycle later identical; occupancy 0→1→0; pkts_out=1.
- m tready=0, push 16 beats → after 16 accepts s tready=0, occupancy=16; 17th beat held on input. Raise m tready → all 16 emerge in order, then the 17th.
- Simultaneous push/pop at occupancy=8 for 50 cycles with random tkeep → occupancy stays 8; scoreboard matches payload order and tid.
- Assert areset low mid-packet with occupancy=5 → same cycle tvalid=0; after release occupancy=0, pkts_stored=0, pkts_out=0, and the first new beat is output correctly.
- Preset pkts_out to 0xFFFFFFFE via 4 billion-cycle force or hierarchical deposit, pop 3 tlast beats → counter 0xFFFFFFFF, 0, 1.
- With HOST_FIFO_SAF_EN:
  - 4-beat packet, last beat delayed 10 cycles → m tvalid stays 0 until tlast is stored, then 4 consecutive beats.
  - 20-beat packet → fallback at occupancy 16, saf_overflow=1.
